// File: rtl/rvc_pack_encoder.sv
// Rewrites eligible RV32I instructions as RVC and packs the 16/32-bit stream into words.
// Compression is built only when RVC_PACK_COMPRESS_EN is defined; otherwise all pass through.
module rvc_pack_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic              flush,
  output logic              flush_ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr
);

  typedef enum logic [0:0] {StEmpty, StHalf} state_e;

  state_e            r_state, w_state_nxt;
  logic [15:0]       r_pend, w_pend_nxt;
  logic              r_out_valid;
  logic [31:0]       r_out_word;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_flush_ack;

  logic              w_is_c;
  logic [15:0]       w_c;
  logic              w_in_fire;
  logic              w_flush_fire;
  logic              w_emit;
  logic [31:0]       w_word;

`ifdef RVC_PACK_COMPRESS_EN
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpReg   = 7'b0110011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [11:0] w_imm_i, w_imm_s;
  logic        w_imm6_ok, w_lw_off_ok, w_sw_off_ok;

  assign w_opc   = in_inst[6:0];
  assign w_rd    = in_inst[11:7];
  assign w_f3    = in_inst[14:12];
  assign w_rs1   = in_inst[19:15];
  assign w_rs2   = in_inst[24:20];
  assign w_f7    = in_inst[31:25];
  assign w_imm_i = in_inst[31:20];
  assign w_imm_s = {in_inst[31:25], in_inst[11:7]};

  // Fits a signed 6-bit immediate when bits [11:5] are all sign copies.
  assign w_imm6_ok   = (w_imm_i[11:5] == 7'h00) || (w_imm_i[11:5] == 7'h7f);
  assign w_lw_off_ok = (w_imm_i[11:7] == 5'h00) && (w_imm_i[1:0] == 2'b00);
  assign w_sw_off_ok = (w_imm_s[11:7] == 5'h00) && (w_imm_s[1:0] == 2'b00);

  always_comb begin
    w_is_c = 1'b0;
    w_c    = 16'h0000;
    if (w_opc == OpImm && w_f3 == 3'b000 && w_rs1 == 5'd0 && w_rd != 5'd0 && w_imm6_ok) begin
      w_is_c = 1'b1;
      w_c    = {3'b010, w_imm_i[5], w_rd, w_imm_i[4:0], 2'b01};
    end else if (w_opc == OpImm && w_f3 == 3'b000 && w_rs1 == w_rd && w_rd != 5'd0 &&
                 w_imm_i != 12'h000 && w_imm6_ok) begin
      w_is_c = 1'b1;
      w_c    = {3'b000, w_imm_i[5], w_rd, w_imm_i[4:0], 2'b01};
    end else if (w_opc == OpImm && w_f3 == 3'b001 && w_f7 == 7'h00 && w_rs1 == w_rd &&
                 w_rd != 5'd0 && w_rs2 != 5'd0) begin
      w_is_c = 1'b1;
      w_c    = {3'b000, 1'b0, w_rd, w_rs2, 2'b10};
    end else if (w_opc == OpReg && w_f3 == 3'b000 && w_f7 == 7'h00 && w_rs1 == 5'd0 &&
                 w_rd != 5'd0 && w_rs2 != 5'd0) begin
      w_is_c = 1'b1;
      w_c    = {4'b1000, w_rd, w_rs2, 2'b10};
    end else if (w_opc == OpReg && w_f3 == 3'b000 && w_f7 == 7'h00 && w_rs1 == w_rd &&
                 w_rd != 5'd0 && w_rs2 != 5'd0) begin
      w_is_c = 1'b1;
      w_c    = {4'b1001, w_rd, w_rs2, 2'b10};
    end else if (w_opc == OpLoad && w_f3 == 3'b010 && w_rd[4:3] == 2'b01 &&
                 w_rs1[4:3] == 2'b01 && w_lw_off_ok) begin
      w_is_c = 1'b1;
      w_c    = {3'b010, w_imm_i[5:3], w_rs1[2:0], w_imm_i[2], w_imm_i[6], w_rd[2:0], 2'b00};
    end else if (w_opc == OpStore && w_f3 == 3'b010 && w_rs2[4:3] == 2'b01 &&
                 w_rs1[4:3] == 2'b01 && w_sw_off_ok) begin
      w_is_c = 1'b1;
      w_c    = {3'b110, w_imm_s[5:3], w_rs1[2:0], w_imm_s[2], w_imm_s[6], w_rs2[2:0], 2'b00};
    end
  end
`else
  assign w_is_c = 1'b0;
  assign w_c    = 16'h0000;
`endif

  assign in_ready  = !r_out_valid || out_ready;
  assign w_in_fire = in_valid && in_ready;
  // A flush waits for an idle input and a free slot; the ack cycle itself never re-fires it.
  assign w_flush_fire = flush && !in_valid && in_ready && !r_flush_ack;

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_emit      = 1'b0;
    w_word      = 32'h0000_0000;
    if (w_in_fire) begin
      unique case (r_state)
        StEmpty: begin
          if (w_is_c) begin
            w_pend_nxt  = w_c;
            w_state_nxt = StHalf;
          end else begin
            w_emit = 1'b1;
            w_word = in_inst;
          end
        end
        StHalf: begin
          w_emit = 1'b1;
          if (w_is_c) begin
            w_word      = {w_c, r_pend};
            w_state_nxt = StEmpty;
          end else begin
            w_word     = {in_inst[15:0], r_pend};
            w_pend_nxt = in_inst[31:16];
          end
        end
        default: w_state_nxt = StEmpty;
      endcase
    end else if (w_flush_fire && r_state == StHalf) begin
      w_emit      = 1'b1;
      w_word      = {16'h0001, r_pend};
      w_state_nxt = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StEmpty;
      r_pend      <= 16'h0000;
      r_out_valid <= 1'b0;
      r_out_word  <= 32'h0000_0000;
      r_out_addr  <= '0;
      r_flush_ack <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend      <= w_pend_nxt;
      r_flush_ack <= w_flush_fire;
      if (r_out_valid && out_ready) begin
        r_out_addr <= r_out_addr + 1'b1;
      end
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_word  <= w_word;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_word  = r_out_word;
  assign out_addr  = r_out_addr;
  assign flush_ack = r_flush_ack;

endmodule

// File: tb/tb_rvc_pack_encoder.sv
// Bench for rvc_pack_encoder: random stream against a halfword-queue reference model,
// plus directed vectors; follows RVC_PACK_COMPRESS_EN like the design.
module tb_rvc_pack_encoder;
  localparam int unsigned ADDR_W = 8;
`ifdef RVC_PACK_COMPRESS_EN
  localparam bit CompressEn = 1'b1;
`else
  localparam bit CompressEn = 1'b0;
`endif

  logic              clk, rst, in_valid, in_ready, flush, flush_ack, out_valid, out_ready;
  logic [31:0]       in_inst, out_word;
  logic [ADDR_W-1:0] out_addr;

  rvc_pack_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_inst  (in_inst),
    .flush    (flush),
    .flush_ack(flush_ack),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word (out_word),
    .out_addr (out_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned       n_checks = 0, n_fail = 0, n_words = 0, n_acks = 0;
  logic [15:0]       hq[$];
  logic [31:0]       exp_q[$];
  logic              last_fire_in = 1'b0, ack_seen = 1'b0, ack_valid = 1'b0;
  logic [31:0]       ack_word = '0;
  logic [ADDR_W-1:0] ack_addr = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference compressor: field values as integers, RVC halfword built by arithmetic.
  function automatic bit ref_compress(input logic [31:0] i, output logic [15:0] c);
    int opc = int'(i[6:0]);
    int f3  = int'(i[14:12]);
    int f7  = int'(i[31:25]);
    int rd  = int'(i[11:7]);
    int rs1 = int'(i[19:15]);
    int rs2 = int'(i[24:20]);
    int imm_i = int'($signed(i[31:20]));
    int imm_s = int'($signed({i[31:25], i[11:7]}));
    bit addi = (opc == 'h13) && (f3 == 0);
    bit add  = (opc == 'h33) && (f3 == 0) && (f7 == 0);
    c = 16'h0000;
    if (!CompressEn) return 1'b0;
    if (addi && rs1 == 0 && rd != 0 && imm_i >= -32 && imm_i <= 31) begin
      c = 16'(32'h4001 + (rd << 7) + ((imm_i & 31) << 2) + (((imm_i >> 5) & 1) << 12));
      return 1'b1;
    end
    if (addi && rs1 == rd && rd != 0 && imm_i != 0 && imm_i >= -32 && imm_i <= 31) begin
      c = 16'(32'h0001 + (rd << 7) + ((imm_i & 31) << 2) + (((imm_i >> 5) & 1) << 12));
      return 1'b1;
    end
    if (opc == 'h13 && f3 == 1 && f7 == 0 && rs1 == rd && rd != 0 && rs2 > 0) begin
      c = 16'(32'h0002 + (rd << 7) + (rs2 << 2));
      return 1'b1;
    end
    if (add && rs1 == 0 && rd != 0 && rs2 != 0) begin
      c = 16'(32'h8002 + (rd << 7) + (rs2 << 2));
      return 1'b1;
    end
    if (add && rs1 == rd && rd != 0 && rs2 != 0) begin
      c = 16'(32'h9002 + (rd << 7) + (rs2 << 2));
      return 1'b1;
    end
    if (opc == 'h03 && f3 == 2 && rd >= 8 && rd <= 15 && rs1 >= 8 && rs1 <= 15 &&
        imm_i >= 0 && imm_i <= 124 && imm_i % 4 == 0) begin
      c = 16'(32'h4000 + (((imm_i >> 3) & 7) << 10) + ((rs1 - 8) << 7) +
              (((imm_i >> 2) & 1) << 6) + (((imm_i >> 6) & 1) << 5) + ((rd - 8) << 2));
      return 1'b1;
    end
    if (opc == 'h23 && f3 == 2 && rs2 >= 8 && rs2 <= 15 && rs1 >= 8 && rs1 <= 15 &&
        imm_s >= 0 && imm_s <= 124 && imm_s % 4 == 0) begin
      c = 16'(32'hC000 + (((imm_s >> 3) & 7) << 10) + ((rs1 - 8) << 7) +
              (((imm_s >> 2) & 1) << 6) + (((imm_s >> 6) & 1) << 5) + ((rs2 - 8) << 2));
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_pack(output int produced);
    produced = 0;
    while (hq.size() >= 2) begin
      exp_q.push_back({hq[1], hq[0]});
      void'(hq.pop_front());
      void'(hq.pop_front());
      produced++;
    end
  endtask

  task automatic model_accept(input logic [31:0] inst, output int produced);
    logic [15:0] c;
    if (ref_compress(inst, c)) begin
      hq.push_back(c);
    end else begin
      hq.push_back(inst[15:0]);
      hq.push_back(inst[31:16]);
    end
    model_pack(produced);
  endtask

  task automatic model_flush(output int produced);
    if (hq.size() == 1) hq.push_back(16'h0001);
    model_pack(produced);
  endtask

  function automatic logic [31:0] enc_i(input int opc, input int f3, input int rd,
                                        input int rs1, input int imm);
    logic [11:0] im = 12'(imm);
    return {im, 5'(rs1), 3'(f3), 5'(rd), 7'(opc)};
  endfunction

  function automatic logic [31:0] enc_r(input int rs2, input int rs1, input int rd);
    return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input int rs2, input int rs1, input int imm);
    logic [11:0] im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] gen_inst();
    int rd  = int'($urandom_range(0, 15));
    int rs  = ($urandom_range(0, 1) != 0) ? rd : int'($urandom_range(0, 15));
    int rs2 = int'($urandom_range(0, 15));
    int imm = int'($urandom_range(0, 90)) - 45;
    int pr  = int'($urandom_range(6, 17));
    int pb  = int'($urandom_range(6, 17));
    int off = int'($urandom_range(0, 35)) * 4 - 8 + (($urandom_range(0, 5) == 0) ? 2 : 0);
    logic [31:0] r = $urandom();
    case ($urandom_range(0, 9))
      0: r = enc_i('h13, 0, rd, 0, imm);
      1: r = enc_i('h13, 0, rd, rs, imm);
      2: r = enc_i('h13, 1, rd, rs,
                   int'($urandom_range(0, 31)) + (($urandom_range(0, 5) == 0) ? 1024 : 0));
      3: r = enc_r(rs2, 0, rd);
      4: r = enc_r(rs2, rs, rd);
      5: r = enc_i('h03, 2, pr, pb, off);
      6: r = enc_s(pr, pb, off);
      7: r[6:0] = ($urandom_range(0, 1) != 0) ? 7'h63 : 7'h6f;
      8: r = enc_i('h73, 0, 0, 0, int'($urandom_range(0, 1)));
      default: ;
    endcase
    return r;
  endfunction

  // One clock: inputs are already driven; sample before and after the rising edge.
  task automatic tick();
    logic              fire_in, fire_out, stalled, pre_flush;
    logic [31:0]       st_word;
    logic [ADDR_W-1:0] st_addr;
    int                prod_in, prod_fl;
    prod_in = 0;
    prod_fl = 0;
    #1;
    check_val("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    fire_in   = in_valid && in_ready;
    fire_out  = out_valid && out_ready;
    stalled   = out_valid && !out_ready;
    st_word   = out_word;
    st_addr   = out_addr;
    pre_flush = flush;
    if (fire_out) begin
      check_val("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check_val("out_word", out_word, exp_q.pop_front());
        check_val("out_addr", 32'(out_addr), 32'(n_words % (1 << ADDR_W)));
      end
      n_words++;
    end
    if (fire_in) model_accept(in_inst, prod_in);
    @(posedge clk);
    #1;
    if (flush_ack) begin
      if (!pre_flush) check_val("ack_spurious", 32'(flush_ack), 32'd0);
      n_acks++;
      ack_seen  = 1'b1;
      ack_valid = out_valid;
      ack_word  = out_word;
      ack_addr  = out_addr;
      model_flush(prod_fl);
    end
    if (prod_in + prod_fl > 0) check_val("out_latency", 32'(out_valid), 32'd1);
    if (stalled) begin
      check_val("stall_valid", 32'(out_valid), 32'd1);
      check_val("stall_word", out_word, st_word);
      check_val("stall_addr", 32'(out_addr), 32'(st_addr));
    end
    last_fire_in = fire_in;
  endtask

  task automatic send(input logic [31:0] inst);
    int n = 0;
    in_valid     = 1'b1;
    in_inst      = inst;
    last_fire_in = 1'b0;
    while (!last_fire_in && n < 40) begin
      tick();
      n++;
    end
    if (!last_fire_in) check_val("accept_timeout", 32'(last_fire_in), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    ack_seen  = 1'b0;
    while (!ack_seen && n < 40) begin
      tick();
      n++;
    end
    check_val("flush_ack_seen", 32'(ack_seen), 32'd1);
    tick();
    check_val("ack_once", 32'(flush_ack), 32'd0);
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    hq.delete();
    exp_q.delete();
    n_words = 0;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_word", out_word, 32'd0);
    check_val("rst_out_addr", 32'(out_addr), 32'd0);
    check_val("rst_flush_ack", 32'(flush_ack), 32'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    int a0;
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
    do_reset();

`ifdef RVC_PACK_COMPRESS_EN
    send(32'h0030_0293);
    check_val("t1_pending", 32'(out_valid), 32'd0);
    send(32'h00B5_0533);
    check_val("t1_word", out_word, 32'h952E_428D);
    check_val("t1_addr", 32'(out_addr), 32'd0);

    do_reset();
    send(32'h0030_0293);
    send(32'h0000_0063);
    check_val("t2_word0", out_word, 32'h0063_428D);
    a0 = int'(n_acks);
    do_flush();
    check_val("t2_flush_valid", 32'(ack_valid), 32'd1);
    check_val("t2_flush_word", ack_word, 32'h0001_0000);
    check_val("t2_flush_addr", 32'(ack_addr), 32'd1);
    check_val("t2_ack_count", 32'(int'(n_acks) - a0), 32'd1);

    do_reset();
    send(32'h0044_A403);
    send(32'h0044_A403);
    check_val("t3_lw_pair", out_word, 32'h40C0_40C0);
    send(32'h0640_0293);
    check_val("t3_addi_big", out_word, 32'h0640_0293);
    do_flush();
    check_val("t3_no_pend", 32'(ack_valid), 32'd0);

    do_reset();
    send(32'h0030_0293);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0000_0063;
    tick();
    in_valid = 1'b0;
    check_val("t5_accept_first", 32'(last_fire_in), 32'd1);
    check_val("t5_ack_deferred", 32'(flush_ack), 32'd0);
    check_val("t5_word", out_word, 32'h0063_428D);
    do_flush();
    check_val("t5_flush_word", ack_word, 32'h0001_0000);
`else
    send(32'h0030_0293);
    check_val("pt_word", out_word, 32'h0030_0293);
    send(32'h00B5_0533);
    check_val("pt_word2", out_word, 32'h00B5_0533);
    check_val("pt_addr2", 32'(out_addr), 32'd1);
    do_flush();
    check_val("pt_flush_noword", 32'(ack_valid), 32'd0);
`endif

    // Backpressure: word held for five cycles, pending instruction kept waiting.
    do_reset();
    send(32'h0000_0063);
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0010_0073;
    repeat (5) tick();
    check_val("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    send(32'h0010_0073);
    send(32'h0000_0013);

    // Reset while a halfword is pending.
    do_reset();
    send(32'h0030_0293);
    do_reset();
    send(32'h0000_0063);
    check_val("rst_half_word", out_word, 32'h0000_0063);
    check_val("rst_half_addr", 32'(out_addr), 32'd0);

    // Address wrap with uncompressible words.
    do_reset();
    for (int k = 0; k < 257; k++) send({25'($urandom()), 7'h63});
    check_val("wrap_addr", 32'(out_addr), 32'd0);
    repeat (3) send({25'($urandom()), 7'h6f});

    // Random stream with random backpressure and occasional flushes.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!in_valid || last_fire_in) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_inst  = gen_inst();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if ($urandom_range(0, 49) == 0) do_flush();
    end

    in_valid = 1'b0;
    do_flush();
    repeat (3) tick();
    check_val("drain_words", 32'(exp_q.size()), 32'd0);
    check_val("drain_halves", 32'(hq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
